// File: rtl/cpu_pkg.sv
// Shared decode types for the RV32I(+M/Zbb/F/Zicsr) front end: opcodes, operation enums and the
// decoded-instruction packet carried from the decode queue into ID/EX.
package cpu_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD     = 5'd0,
        ALU_SUB     = 5'd1,
        ALU_SLL     = 5'd2,
        ALU_SLT     = 5'd3,
        ALU_SLTU    = 5'd4,
        ALU_XOR     = 5'd5,
        ALU_SRL     = 5'd6,
        ALU_SRA     = 5'd7,
        ALU_OR      = 5'd8,
        ALU_AND     = 5'd9,
        ALU_MUL     = 5'd10,
        ALU_MULH    = 5'd11,
        ALU_MULHSU  = 5'd12,
        ALU_MULHU   = 5'd13,
        ALU_ANDN    = 5'd14,
        ALU_ORN     = 5'd15,
        ALU_XNOR    = 5'd16,
        ALU_MIN     = 5'd17,
        ALU_MINU    = 5'd18,
        ALU_MAX     = 5'd19,
        ALU_MAXU    = 5'd20,
        ALU_SEXTB   = 5'd21,
        ALU_PASSB   = 5'd22,
        ALU_FADD    = 5'd23,
        ALU_FSUB    = 5'd24,
        ALU_RETURN1 = 5'd25
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_DM  = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_sel_e;

    typedef enum logic [2:0] {
        DM_RD_NONE = 3'd0,
        DM_RD_LB   = 3'd1,
        DM_RD_LH   = 3'd2,
        DM_RD_LW   = 3'd3,
        DM_RD_LBU  = 3'd4,
        DM_RD_LHU  = 3'd5
    } dm_rd_e;

    typedef enum logic [1:0] {
        DM_WR_NONE = 2'd0,
        DM_WR_SB   = 2'd1,
        DM_WR_SH   = 2'd2,
        DM_WR_SW   = 2'd3
    } dm_wr_e;

    typedef struct packed {
        logic        illegal;
        alu_op_e     aluop;
        logic        alu_a_pc;
        logic        alu_b_imm;
        logic        fp_op;
        wb_sel_e     wb_sel;
        logic        wb_en;
        logic        wb_en_f;
        dm_rd_e      dm_read;
        dm_wr_e      dm_write;
        logic        jal;
        logic        jalr;
        logic        branch;
        logic [2:0]  br_funct3;
        csr_sel_e    csr_sel;
        logic        csr_imm;
        logic [11:0] csr_addr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } decode_pkt_t;

endpackage

// File: rtl/inst_decode_core.sv
// Purely combinational RV32I(+M/Zbb/F/Zicsr) instruction decoder with per-extension enables,
// illegal-instruction flagging and optional x0 write suppression.
module inst_decode_core
    import cpu_pkg::*;
#(
    parameter bit EN_M        = 1'b1,
    parameter bit EN_ZBB      = 1'b1,
    parameter bit EN_F        = 1'b1,
    parameter bit EN_CSR      = 1'b1,
    parameter bit SUPPRESS_X0 = 1'b1
) (
    input  logic [31:0] i_inst,
    output decode_pkt_t o_pkt
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  funct5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ill;
    decode_pkt_t pkt;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign funct5 = i_inst[31:27];
    assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u  = {i_inst[31:12], 12'h000};
    assign imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        pkt          = '0;
        ill          = 1'b0;
        pkt.rs1      = i_inst[19:15];
        pkt.rs2      = i_inst[24:20];
        pkt.rd       = i_inst[11:7];
        pkt.csr_addr = i_inst[31:20];
        pkt.aluop    = ALU_ADD;
        pkt.wb_sel   = WB_ALU;
        pkt.dm_read  = DM_RD_NONE;
        pkt.dm_write = DM_WR_NONE;
        pkt.csr_sel  = CSR_NONE;

        case (opcode)
            OPC_OP: begin
                pkt.wb_en = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  pkt.aluop = ALU_ADD;
                            3'b001:  pkt.aluop = ALU_SLL;
                            3'b010:  pkt.aluop = ALU_SLT;
                            3'b011:  pkt.aluop = ALU_SLTU;
                            3'b100:  pkt.aluop = ALU_XOR;
                            3'b101:  pkt.aluop = ALU_SRL;
                            3'b110:  pkt.aluop = ALU_OR;
                            default: pkt.aluop = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  pkt.aluop = ALU_SUB;
                            3'b101:  pkt.aluop = ALU_SRA;
                            3'b111:  begin pkt.aluop = ALU_ANDN; ill = !EN_ZBB; end
                            3'b110:  begin pkt.aluop = ALU_ORN;  ill = !EN_ZBB; end
                            3'b100:  begin pkt.aluop = ALU_XNOR; ill = !EN_ZBB; end
                            default: ill = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        // Only the multiply half of M is implemented; divides have no mapping.
                        if (!EN_M || funct3[2]) begin
                            ill = 1'b1;
                        end else begin
                            case (funct3[1:0])
                                2'b00:   pkt.aluop = ALU_MUL;
                                2'b01:   pkt.aluop = ALU_MULH;
                                2'b10:   pkt.aluop = ALU_MULHSU;
                                default: pkt.aluop = ALU_MULHU;
                            endcase
                        end
                    end
                    7'b0000101: begin
                        if (!EN_ZBB || !funct3[2]) begin
                            ill = 1'b1;
                        end else begin
                            case (funct3[1:0])
                                2'b00:   pkt.aluop = ALU_MIN;
                                2'b01:   pkt.aluop = ALU_MINU;
                                2'b10:   pkt.aluop = ALU_MAX;
                                default: pkt.aluop = ALU_MAXU;
                            endcase
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                pkt.wb_en     = 1'b1;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_i;
                case (funct3)
                    3'b000: pkt.aluop = ALU_ADD;
                    3'b010: pkt.aluop = ALU_SLT;
                    3'b011: pkt.aluop = ALU_SLTU;
                    3'b100: pkt.aluop = ALU_XOR;
                    3'b110: pkt.aluop = ALU_OR;
                    3'b111: pkt.aluop = ALU_AND;
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            pkt.aluop = ALU_SLL;
                        end else if (EN_ZBB && i_inst[31:20] == 12'h604) begin
                            pkt.aluop = ALU_SEXTB;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      pkt.aluop = ALU_SRL;
                        else if (funct7 == 7'b0100000) pkt.aluop = ALU_SRA;
                        else                           ill = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                pkt.wb_en     = 1'b1;
                pkt.aluop     = ALU_PASSB;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_u;
            end
            OPC_AUIPC: begin
                pkt.wb_en     = 1'b1;
                pkt.alu_a_pc  = 1'b1;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_u;
            end
            OPC_JAL: begin
                pkt.jal    = 1'b1;
                pkt.wb_en  = 1'b1;
                pkt.wb_sel = WB_PC4;
                pkt.imm    = imm_j;
            end
            OPC_JALR: begin
                ill           = (funct3 != 3'b000);
                pkt.jalr      = 1'b1;
                pkt.wb_en     = 1'b1;
                pkt.wb_sel    = WB_PC4;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_i;
            end
            OPC_BRANCH: begin
                ill           = (funct3[2:1] == 2'b01);
                pkt.branch    = 1'b1;
                pkt.br_funct3 = funct3;
                pkt.aluop     = ALU_SUB;
                pkt.imm       = imm_b;
            end
            OPC_LOAD: begin
                pkt.wb_en     = 1'b1;
                pkt.wb_sel    = WB_DM;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_i;
                case (funct3)
                    3'b000:  pkt.dm_read = DM_RD_LB;
                    3'b001:  pkt.dm_read = DM_RD_LH;
                    3'b010:  pkt.dm_read = DM_RD_LW;
                    3'b100:  pkt.dm_read = DM_RD_LBU;
                    3'b101:  pkt.dm_read = DM_RD_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_s;
                case (funct3)
                    3'b000:  pkt.dm_write = DM_WR_SB;
                    3'b001:  pkt.dm_write = DM_WR_SH;
                    3'b010:  pkt.dm_write = DM_WR_SW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_MISC_MEM: ill = (funct3[2:1] != 2'b00);
            OPC_LOAD_FP: begin
                ill           = !EN_F || (funct3 != 3'b010);
                pkt.fp_op     = 1'b1;
                pkt.wb_en_f   = 1'b1;
                pkt.wb_sel    = WB_DM;
                pkt.dm_read   = DM_RD_LW;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_i;
            end
            OPC_STORE_FP: begin
                ill           = !EN_F || (funct3 != 3'b010);
                pkt.fp_op     = 1'b1;
                pkt.dm_write  = DM_WR_SW;
                pkt.alu_b_imm = 1'b1;
                pkt.imm       = imm_s;
            end
            OPC_OP_FP: begin
                pkt.fp_op   = 1'b1;
                pkt.wb_en_f = 1'b1;
                if (!EN_F || i_inst[26:25] != 2'b00) begin
                    ill = 1'b1;
                end else begin
                    case (funct5)
                        5'b00000: pkt.aluop = ALU_FADD;
                        5'b00001: pkt.aluop = ALU_FSUB;
                        default:  ill = 1'b1;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                // funct3 000 (ecall/ebreak/xret) is legal but touches no CSR or register.
                if (!EN_CSR || funct3 == 3'b100) begin
                    ill = 1'b1;
                end else if (funct3 != 3'b000) begin
                    pkt.csr_sel = csr_sel_e'(funct3[1:0]);
                    pkt.csr_imm = funct3[2];
                    pkt.wb_sel  = WB_CSR;
                    pkt.wb_en   = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase

        if (i_inst[1:0] != 2'b11) ill = 1'b1;

        if (ill) begin
            pkt.aluop    = ALU_RETURN1;
            pkt.wb_sel   = WB_ALU;
            pkt.wb_en    = 1'b0;
            pkt.wb_en_f  = 1'b0;
            pkt.dm_read  = DM_RD_NONE;
            pkt.dm_write = DM_WR_NONE;
            pkt.jal      = 1'b0;
            pkt.jalr     = 1'b0;
            pkt.branch   = 1'b0;
            pkt.csr_sel  = CSR_NONE;
        end
        pkt.illegal = ill;

        if (SUPPRESS_X0 && pkt.rd == 5'd0) pkt.wb_en = 1'b0;
    end

    assign o_pkt = pkt;

endmodule

// File: rtl/decode_stage_q.sv
// Registered decode stage: instructions are decoded on enqueue into a DEPTH-entry FIFO and
// presented in order to ID/EX with valid/ready handshaking and a flush.
module decode_stage_q
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned PC_W        = 32,
    parameter bit          EN_M        = 1'b1,
    parameter bit          EN_ZBB      = 1'b1,
    parameter bit          EN_F        = 1'b1,
    parameter bit          EN_CSR      = 1'b1,
    parameter bit          SUPPRESS_X0 = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [PC_W-1:0]          i_pc,
    input  logic [31:0]              i_inst,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [PC_W-1:0]          o_pc,
    output decode_pkt_t              o_pkt,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PC_W-1:0] pc_mem_q  [DEPTH];
    decode_pkt_t     pkt_mem_q [DEPTH];
    decode_pkt_t     dec_pkt;
    logic            push, pop;

    inst_decode_core #(
        .EN_M        (EN_M),
        .EN_ZBB      (EN_ZBB),
        .EN_F        (EN_F),
        .EN_CSR      (EN_CSR),
        .SUPPRESS_X0 (SUPPRESS_X0)
    ) u_core (
        .i_inst (i_inst),
        .o_pkt  (dec_pkt)
    );

    // Ready depends on occupancy only, so a full queue never accepts even when popping.
    assign o_ready = (count_q != CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign o_count = count_q;
    assign o_pc    = pc_mem_q[rd_ptr_q];
    assign o_pkt   = pkt_mem_q[rd_ptr_q];

    always_comb begin
        push     = i_valid && o_ready && !i_flush;
        pop      = o_valid && i_ready && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]  <= '0;
                pkt_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]  <= i_pc;
            pkt_mem_q[wr_ptr_q] <= dec_pkt;
        end
    end

endmodule

// File: tb/tb_decode_stage_q.sv
// Scoreboard bench for decode_stage_q: directed instructions with hand-decoded expectations,
// checked in order by monitors on two instances (M enabled / M disabled).
`timescale 1ns/1ps
module tb_decode_stage_q;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready_in = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;

    logic        rdy_m, vld_m, rdy_n, vld_n;
    logic [31:0] opc_m, opc_n;
    decode_pkt_t pkt_m, pkt_n;
    logic [1:0]  cnt_m, cnt_n;

    always #5 clk = ~clk;

    decode_stage_q #(
        .DEPTH(2), .PC_W(32), .EN_M(1'b1), .EN_ZBB(1'b1), .EN_F(1'b1), .EN_CSR(1'b1),
        .SUPPRESS_X0(1'b1)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy_m),
        .i_pc(pc), .i_inst(inst), .o_valid(vld_m), .i_ready(ready_in), .o_pc(opc_m),
        .o_pkt(pkt_m), .o_count(cnt_m)
    );

    decode_stage_q #(
        .DEPTH(2), .PC_W(32), .EN_M(1'b0), .EN_ZBB(1'b1), .EN_F(1'b1), .EN_CSR(1'b1),
        .SUPPRESS_X0(1'b1)
    ) u_dut_nom (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy_n),
        .i_pc(pc), .i_inst(inst), .o_valid(vld_n), .i_ready(ready_in), .o_pc(opc_n),
        .o_pkt(pkt_n), .o_count(cnt_n)
    );

    typedef struct {
        logic [31:0] pc;
        logic        ill;
        alu_op_e     aluop;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wb_en;
        wb_sel_e     wb_sel;
        dm_rd_e      dm_read;
        dm_wr_e      dm_write;
    } exp_t;

    exp_t q_m[$];
    exp_t q_n[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input logic ill, input alu_op_e op,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic wb_en, input wb_sel_e ws,
                                input dm_rd_e dr, input dm_wr_e dw);
        exp_t e;
        e.pc = p; e.ill = ill; e.aluop = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.wb_en = wb_en; e.wb_sel = ws; e.dm_read = dr; e.dm_write = dw;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] p, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [4:0] rd);
        return mk(p, 1'b1, ALU_RETURN1, rs1, rs2, rd, 1'b0, WB_ALU, DM_RD_NONE, DM_WR_NONE);
    endfunction

    always @(negedge clk) begin : mon_m
        exp_t e;
        if (rst_n && !flush && vld_m && ready_in) begin
            if (q_m.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m_unexpected_output: got pc 0x%0h expected no output", opc_m);
            end else begin
                e = q_m.pop_front();
                chk("m_pc", opc_m, e.pc);
                chk("m_illegal", pkt_m.illegal, e.ill);
                chk("m_aluop", pkt_m.aluop, e.aluop);
                chk("m_rs1", pkt_m.rs1, e.rs1);
                chk("m_rs2", pkt_m.rs2, e.rs2);
                chk("m_rd", pkt_m.rd, e.rd);
                chk("m_wb_en", pkt_m.wb_en, e.wb_en);
                chk("m_wb_sel", pkt_m.wb_sel, e.wb_sel);
                chk("m_dm_read", pkt_m.dm_read, e.dm_read);
                chk("m_dm_write", pkt_m.dm_write, e.dm_write);
            end
        end
    end

    always @(negedge clk) begin : mon_n
        exp_t e;
        if (rst_n && !flush && vld_n && ready_in) begin
            if (q_n.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL n_unexpected_output: got pc 0x%0h expected no output", opc_n);
            end else begin
                e = q_n.pop_front();
                chk("n_pc", opc_n, e.pc);
                chk("n_illegal", pkt_n.illegal, e.ill);
                chk("n_aluop", pkt_n.aluop, e.aluop);
                chk("n_wb_en", pkt_n.wb_en, e.wb_en);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [31:0] p, input logic [31:0] in, input exp_t em,
                        input exp_t en, input bit track);
        int n;
        n = 0;
        pc = p;
        inst = in;
        valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (rdy_m) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got o_ready 0 for pc 0x%0h expected 1", p);
                valid = 1'b0;
                return;
            end
        end
        if (track) begin
            q_m.push_back(em);
            q_n.push_back(en);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_m.size() != 0 || q_n.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q_m.size() != 0 || q_n.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d/%0d pending expected 0", name, q_m.size(),
                     q_n.size());
        end
        chk({name, "_empty_valid"}, vld_m, 1'b0);
    endtask

    initial begin
        exp_t e;
        #2;
        chk("rst_valid", vld_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_count", cnt_m, 2'd0);
        chk("rst_pc", opc_m, 32'h0);
        chk("rst_pkt_zero", pkt_m, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_in = 1'b1;

        // add x3,x1,x2: visible the cycle after the push
        e = mk(32'h100, 1'b0, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h100, 32'h002081B3, e, e, 1'b1);
        chk("t1_latency_valid", vld_m, 1'b1);
        chk("t1_latency_count", cnt_m, 2'd1);

        // mul: legal with M, illegal without
        send(32'h104, 32'h022081B3,
             mk(32'h104, 1'b0, ALU_MUL, 5'd1, 5'd2, 5'd3, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE),
             mk_ill(32'h104, 5'd1, 5'd2, 5'd3), 1'b1);
        // addi x0,x0,0 (x0 write suppressed) and lw x5,8(x2)
        e = mk(32'h108, 1'b0, ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b0, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h108, 32'h00000013, e, e, 1'b1);
        e = mk(32'h10C, 1'b0, ALU_ADD, 5'd2, 5'd8, 5'd5, 1'b1, WB_DM, DM_RD_LW, DM_WR_NONE);
        send(32'h10C, 32'h00812283, e, e, 1'b1);
        // compressed encoding, CSR funct3=100, Zbb min x5,x6,x7
        e = mk_ill(32'h110, 5'd0, 5'd0, 5'd0);
        send(32'h110, 32'h00000001, e, e, 1'b1);
        e = mk_ill(32'h114, 5'd0, 5'd0, 5'd0);
        send(32'h114, 32'h30004073, e, e, 1'b1);
        e = mk(32'h118, 1'b0, ALU_MIN, 5'd6, 5'd7, 5'd5, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h118, 32'h0A7342B3, e, e, 1'b1);
        drain("t125");

        // Backpressure: fill, then push while full and popping
        ready_in = 1'b0;
        e = mk(32'h120, 1'b0, ALU_ADD, 5'd0, 5'd1, 5'd1, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h120, 32'h00100093, e, e, 1'b1);
        e = mk(32'h124, 1'b0, ALU_ADD, 5'd0, 5'd2, 5'd2, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h124, 32'h00200113, e, e, 1'b1);
        chk("t3_full_count", cnt_m, 2'd2);
        chk("t3_full_ready", rdy_m, 1'b0);
        ready_in = 1'b1;
        pc = 32'h128;
        inst = 32'h407302B3;
        valid = 1'b1;
        @(negedge clk);
        chk("t3_full_pop_ready", rdy_m, 1'b0);
        @(posedge clk);
        #1;
        chk("t3_blocked_count", cnt_m, 2'd1);
        @(negedge clk);
        chk("t3_ready_back", rdy_m, 1'b1);
        e = mk(32'h128, 1'b0, ALU_SUB, 5'd6, 5'd7, 5'd5, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        q_m.push_back(e);
        q_n.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("t3_push_pop_count", cnt_m, 2'd1);
        drain("t3");

        // Flush a full queue together with a valid input
        ready_in = 1'b0;
        send(32'h200, 32'h002081B3, e, e, 1'b0);
        send(32'h204, 32'h002081B3, e, e, 1'b0);
        chk("t4_full_count", cnt_m, 2'd2);
        flush = 1'b1;
        valid = 1'b1;
        pc = 32'h208;
        inst = 32'h002081B3;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        chk("t4_flush_valid", vld_m, 1'b0);
        chk("t4_flush_count", cnt_m, 2'd0);
        chk("t4_flush_ready", rdy_m, 1'b1);
        ready_in = 1'b1;
        e = mk(32'h20C, 1'b0, ALU_ADD, 5'd0, 5'd1, 5'd1, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h20C, 32'h00100093, e, e, 1'b1);
        drain("t4");

        // Async reset while full and mid-pop
        ready_in = 1'b0;
        e = mk(32'h300, 1'b0, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h300, 32'h002081B3, e, e, 1'b1);
        send(32'h304, 32'h00812283, e, e, 1'b1);
        chk("t6_full_count", cnt_m, 2'd2);
        ready_in = 1'b1;
        #2;
        q_m.delete();
        q_n.delete();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", vld_m, 1'b0);
        chk("t6_rst_count", cnt_m, 2'd0);
        chk("t6_rst_pkt_zero", pkt_m, '0);
        chk("t6_rst_pc", opc_m, 32'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_after_valid", vld_m, 1'b0);
        chk("t6_after_ready", rdy_m, 1'b1);
        e = mk(32'h400, 1'b0, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, WB_ALU, DM_RD_NONE, DM_WR_NONE);
        send(32'h400, 32'h002081B3, e, e, 1'b1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
